pb_conditioner: RTL and testbench

- Front-end stage between the raw push-button pins and every button consumer: the calendar, changeClock, the display mux select and reset distribution.
- Per channel it does three things: 2-FF synchronization, counter-based debounce, and press/release edge pulse generation.
- Optional auto-repeat lets holding an increment button step the value continuously.
- Runs in the fast board-clock domain. All outputs are registered and synchronous to clk.

---
 rtl/pb_conditioner.sv | 219 +++++++++++++++++++++
 tb/tb_pb_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_conditioner.sv
// Push-button front end: 2-FF sync, counter debounce, press/release pulses per channel.
// Auto-repeat (REPEAT state, hold counters, pb_long) is built only when PB_AUTOREPEAT_EN is defined.
module pb_conditioner #(
  parameter int                 NUM_BTN         = 7,
  parameter int                 DEBOUNCE_CYCLES = 120000,
  parameter int                 REPEAT_DELAY    = 6000000,
  parameter int                 REPEAT_PERIOD   = 1200000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 7'b1111100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] pb_raw,
  output logic [NUM_BTN-1:0] pb_level,
  output logic [NUM_BTN-1:0] pb_press,
  output logic [NUM_BTN-1:0] pb_release,
  output logic [NUM_BTN-1:0] pb_long
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];

  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];

  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;

  logic [NUM_BTN-1:0] toggle, rise_evt, fall_evt, rep_evt;

`ifdef PB_AUTOREPEAT_EN
  localparam int DLY_W  = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int PER_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int HOLD_W = (DLY_W > PER_W) ? DLY_W : PER_W;
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = '1;

  logic [HOLD_W-1:0]  hold_q [NUM_BTN];
  logic [HOLD_W-1:0]  hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_q, long_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (|REPEAT_MASK) ^ (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= pb_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // The stable counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign toggle   = level_d ^ level_q;
  assign rise_evt = toggle & ~level_q;
  assign fall_evt = toggle & level_q;

`ifdef PB_AUTOREPEAT_EN
  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (state_q[i] == HELD) begin
        rep_evt[i] = REPEAT_MASK[i] && (hold_q[i] == DELAY_LAST);
      end else if (state_q[i] == REPEAT) begin
        rep_evt[i] = (hold_q[i] == PERIOD_LAST);
      end
    end
  end
`else
  assign rep_evt = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
`ifdef PB_AUTOREPEAT_EN
        hold_q[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
`ifdef PB_AUTOREPEAT_EN
        hold_q[i]  <= hold_d[i];
`endif
      end
    end
  end

  // A falling level always takes priority over a repeat due in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
`ifdef PB_AUTOREPEAT_EN
      hold_d[i]  = hold_q[i];
`endif
      case (state_q[i])
        IDLE: begin
`ifdef PB_AUTOREPEAT_EN
          hold_d[i] = '0;
`endif
          if (rise_evt[i]) begin
            state_d[i] = HELD;
          end
        end
        HELD, REPEAT: begin
          if (fall_evt[i]) begin
            state_d[i] = IDLE;
`ifdef PB_AUTOREPEAT_EN
            hold_d[i]  = '0;
`endif
          end else if (rep_evt[i]) begin
            state_d[i] = REPEAT;
`ifdef PB_AUTOREPEAT_EN
            hold_d[i]  = '0;
`endif
          end else begin
`ifdef PB_AUTOREPEAT_EN
            if (hold_q[i] != HOLD_MAX) begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    press_d   = '0;
    release_d = '0;
`ifdef PB_AUTOREPEAT_EN
    long_d    = '0;
`endif
    for (int i = 0; i < NUM_BTN; i++) begin
      case (state_q[i])
        IDLE: begin
          press_d[i] = rise_evt[i];
        end
        HELD, REPEAT: begin
          release_d[i] = fall_evt[i];
          press_d[i]   = ~fall_evt[i] & rep_evt[i];
        end
        default: begin
          press_d[i] = 1'b0;
        end
      endcase
`ifdef PB_AUTOREPEAT_EN
      long_d[i] = (state_d[i] == REPEAT);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
`ifdef PB_AUTOREPEAT_EN
      long_q    <= '0;
`endif
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
`ifdef PB_AUTOREPEAT_EN
      long_q    <= long_d;
`endif
    end
  end

  assign pb_level   = level_q;
  assign pb_press   = press_q;
  assign pb_release = release_q;
`ifdef PB_AUTOREPEAT_EN
  assign pb_long    = long_q;
`else
  assign pb_long    = '0;
`endif

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with small debounce/repeat parameters.
// Observed vector layout: [2:0] press, [5:3] release, [8:6] long, [11:9] level.
module tb_pb_conditioner;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] pb_raw = '0;
  logic [N-1:0] pb_level, pb_press, pb_release, pb_long;

  int total = 0;
  int bad   = 0;

  pb_conditioner #(
    .NUM_BTN(3),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5),
    .REPEAT_MASK(3'b110)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pb_raw(pb_raw),
    .pb_level(pb_level),
    .pb_press(pb_press),
    .pb_release(pb_release),
    .pb_long(pb_long)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {pb_level, pb_long, pb_release, pb_press};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pb_raw = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    reset  = 1'b1;
    pb_raw = '1;
    step();
    step();
    got = obs();
    total++;
    if (got !== 12'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%b want=%b", got, 12'd0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      got = obs();
      exp = '0;
      if (k == 6) exp[2:0] = 3'b111;
      if (k >= 6) exp[11:9] = 3'b111;
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL held_through_reset k=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [11:0] got, exp;
    do_reset();
    pb_raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) pb_raw[0] = 1'b0;
      got = obs();
      exp = '0;
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL glitch k=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] got, exp;
    do_reset();
    pb_raw[0] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 10) pb_raw[0] = 1'b0;
      got = obs();
      exp = '0;
      exp[0] = (k == 6);
      exp[3] = (k == 16);
      exp[9] = (k >= 6) && (k < 16);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL clean_press k=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

`ifdef PB_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic [11:0] got, exp;
    do_reset();
    pb_raw[1:0] = 2'b11;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 48) pb_raw[1:0] = 2'b00;
      got = obs();
      exp = '0;
      exp[0]  = (k == 6);
      exp[1]  = (k == 6) || ((k >= 26) && (k <= 51) && ((k - 26) % 5 == 0));
      exp[3]  = (k == 54);
      exp[4]  = (k == 54);
      exp[7]  = (k >= 26) && (k < 54);
      exp[9]  = (k >= 6) && (k < 54);
      exp[10] = (k >= 6) && (k < 54);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL autorepeat k=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_collision();
    logic [11:0] got, exp;
    do_reset();
    pb_raw[2] = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      if (k == 30) pb_raw[2] = 1'b0;
      got = obs();
      exp = '0;
      exp[2]  = (k == 6) || (k == 26) || (k == 31);
      exp[5]  = (k == 36);
      exp[8]  = (k >= 26) && (k < 36);
      exp[11] = (k >= 6) && (k < 36);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL collision k=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [11:0] got, exp;
    do_reset();
    pb_raw[1] = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      step();
    end
    got = obs();
    exp = '0;
    exp[7]  = 1'b1;
    exp[10] = 1'b1;
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL in_repeat_before_reset got=%b want=%b", got, exp);
    end
    reset = 1'b1;
    #1;
    got = obs();
    total++;
    if (got !== 12'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%b want=%b", got, 12'd0);
    end
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      got = obs();
      exp = '0;
      exp[1]  = (k == 6);
      exp[10] = (k >= 6);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL after_reset k=%0d got=%b want=%b", k, got, exp);
      end
    end
    pb_raw = '0;
  endtask
`else
  task automatic test_no_repeat();
    logic [11:0] got, exp;
    do_reset();
    pb_raw[1:0] = 2'b11;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 48) pb_raw[1:0] = 2'b00;
      got = obs();
      exp = '0;
      exp[0]  = (k == 6);
      exp[1]  = (k == 6);
      exp[3]  = (k == 54);
      exp[4]  = (k == 54);
      exp[9]  = (k >= 6) && (k < 54);
      exp[10] = (k >= 6) && (k < 54);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL no_repeat k=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
`ifdef PB_AUTOREPEAT_EN
    test_autorepeat();
    test_collision();
    test_reset_mid_repeat();
`else
    test_no_repeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
